// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the unified instruction/data memory.
// Lane numbering is big-endian: byte offset 0 is the most significant byte of a word.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    // Upper bound on bytes per word; callers slice the low BYTES enables.
    localparam int unsigned MaxBytes = 16;

    // Bit i enables the byte at offset i.
    function automatic logic [MaxBytes-1:0] byte_enables(input mem_size_e   size,
                                                         input int unsigned offset,
                                                         input int unsigned nbytes);
        logic [MaxBytes-1:0] be;
        be = '0;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            case (size)
                SZ_BYTE: be[i] = (i == offset);
                SZ_HALF: be[i] = (i == offset) || (i == offset + 1);
                SZ_WORD: be[i] = (i < nbytes);
                default: be[i] = 1'b0;
            endcase
        end
        return be;
    endfunction

    function automatic logic misaligned(input mem_size_e size, input int unsigned offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = (offset % 2) != 0;
            SZ_WORD: mis = (offset != 0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction with sign/zero extension for big-endian byte lanes.
// The addressed byte or halfword is shifted to the top of the word and then extended.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFF_W = 2
) (
    input  logic [WIDTH-1:0] word_i,
    input  mem_size_e        size_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic             unsigned_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] shifted;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    always_comb begin
        shifted  = word_i << {offset_i, 3'b000};
        byte_v   = shifted[WIDTH-1 -: 8];
        half_v   = shifted[WIDTH-1 -: 16];
        result_o = '0;
        case (size_i)
            SZ_BYTE: result_o = {{(WIDTH-8){~unsigned_i & byte_v[7]}}, byte_v};
            SZ_HALF: result_o = {{(WIDTH-16){~unsigned_i & half_v[15]}}, half_v};
            SZ_WORD: result_o = word_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_unified_pipelined.sv
// Unified instruction/data memory: byte-addressed, big-endian sub-word access,
// registered reads with 1 or 2 cycles of latency and misaligned-access flagging.
module mem_unified_pipelined
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 8192,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0]      i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req_valid,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  d_rvalid,
    output logic                  d_misaligned
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [OFF_W-1:0]    d_off;
    logic [IDX_W-1:0]    d_idx;
    logic [IDX_W-1:0]    i_idx;
    mem_size_e           d_size_e;
    logic                d_mis;
    logic [MaxBytes-1:0] d_be_full;
    logic [BYTES-1:0]    d_be;
    logic [WIDTH-1:0]    d_wdata_al;
    logic                store_en;
    logic                load_req;

    // Upper address bits alias and the instruction offset is ignored.
    logic unused_bits;
    assign unused_bits = ^{i_addr, d_addr, d_be_full};

    always_comb begin
        d_off     = d_addr[OFF_W-1:0];
        d_idx     = d_addr[OFF_W +: IDX_W];
        i_idx     = i_addr[OFF_W +: IDX_W];
        d_size_e  = mem_size_e'(d_size);
        d_mis     = misaligned(d_size_e, 32'(d_off));
        d_be_full = byte_enables(d_size_e, 32'(d_off), BYTES);
        d_be      = d_be_full[BYTES-1:0];
        // Right-justified store data is moved to the top lane, then down to its offset.
        case (d_size_e)
            SZ_BYTE: d_wdata_al = {d_wdata[7:0], {(WIDTH-8){1'b0}}} >> {d_off, 3'b000};
            SZ_HALF: d_wdata_al = {d_wdata[15:0], {(WIDTH-16){1'b0}}} >> {d_off, 3'b000};
            default: d_wdata_al = d_wdata;
        endcase
        store_en = rst_n & d_req_valid & d_we & ~d_mis;
        load_req = d_req_valid & ~d_we;
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (d_be[b]) begin
                    mem_q[d_idx][(BYTES-1-b)*8 +: 8] <= d_wdata_al[(BYTES-1-b)*8 +: 8];
                end
            end
        end
    end

    // Stage 1: array sampled at the request edge, so same-edge stores are not seen.
    logic             i_vld_q;
    logic [WIDTH-1:0] i_word_q;
    logic             d_vld_q;
    logic [WIDTH-1:0] d_word_q;
    mem_size_e        d_size_q;
    logic [OFF_W-1:0] d_off_q;
    logic             d_uns_q;
    logic             d_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_vld_q  <= 1'b0;
            i_word_q <= '0;
            d_vld_q  <= 1'b0;
            d_word_q <= '0;
            d_size_q <= SZ_WORD;
            d_off_q  <= '0;
            d_uns_q  <= 1'b0;
            d_mis_q  <= 1'b0;
        end else begin
            i_vld_q <= i_req_valid;
            d_vld_q <= load_req;
            if (i_req_valid) begin
                i_word_q <= mem_q[i_idx];
            end
            if (load_req) begin
                d_word_q <= mem_q[d_idx];
                d_size_q <= d_size_e;
                d_off_q  <= d_off;
                d_uns_q  <= d_unsigned;
                d_mis_q  <= d_mis;
            end
        end
    end

    logic [WIDTH-1:0] d_align;
    logic [WIDTH-1:0] d_ext;

    mem_load_align #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W)
    ) u_load_align (
        .word_i     (d_word_q),
        .size_i     (d_size_q),
        .offset_i   (d_off_q),
        .unsigned_i (d_uns_q),
        .result_o   (d_align)
    );

    assign d_ext = d_mis_q ? '0 : d_align;

    if (READ_LATENCY == 2) begin : g_lat2
        logic             i_vld2_q;
        logic [WIDTH-1:0] i_data2_q;
        logic             d_vld2_q;
        logic             d_mis2_q;
        logic [WIDTH-1:0] d_data2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                i_vld2_q  <= 1'b0;
                i_data2_q <= '0;
                d_vld2_q  <= 1'b0;
                d_mis2_q  <= 1'b0;
                d_data2_q <= '0;
            end else begin
                i_vld2_q <= i_vld_q;
                d_vld2_q <= d_vld_q;
                if (i_vld_q) begin
                    i_data2_q <= i_word_q;
                end
                if (d_vld_q) begin
                    d_mis2_q  <= d_mis_q;
                    d_data2_q <= d_ext;
                end
            end
        end

        assign i_rvalid     = i_vld2_q;
        assign i_rdata      = i_data2_q;
        assign d_rvalid     = d_vld2_q;
        assign d_misaligned = d_vld2_q & d_mis2_q;
        assign d_rdata      = d_data2_q;
    end else begin : g_lat1
        // Stage-1 registers only load on a request, so outputs hold between valids.
        assign i_rvalid     = i_vld_q;
        assign i_rdata      = i_word_q;
        assign d_rvalid     = d_vld_q;
        assign d_misaligned = d_vld_q & d_mis_q;
        assign d_rdata      = d_ext;
    end

endmodule

// File: doc/mem_unified_pipelined.md
Name: mem_unified_pipelined

Overview:
Parametrised successor to the single-cycle unified instruction/data memory of the MIPS core. Both ports are byte-addressed and consistently decoded. The data port supports byte, halfword and word loads/stores with big-endian lanes and sign/zero extension. Reads have a configurable registered latency with valid strobes, and misaligned data accesses are flagged. Sits between the fetch stage (instruction port) and the MEM stage (data port).

Parameters:
ADDR_WIDTH, 32, width of both byte address buses
WIDTH, 32, word width in bits; must be a multiple of 8; BYTES = WIDTH/8
DEPTH, 8192, number of words; must be a power of two
READ_LATENCY, 1, cycles from accepted read request to rvalid; legal values 1 or 2

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
i_req_valid  in  1  instruction read request this cycle
i_addr  in  ADDR_WIDTH  instruction byte address
i_rdata  out  WIDTH  fetched word
i_rvalid  out  1  i_rdata valid, one pulse per request
d_req_valid  in  1  data request this cycle
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
d_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
d_rdata  out  WIDTH  extended load result
d_rvalid  out  1  load result (or error response) valid
d_misaligned  out  1  qualifies d_rvalid: access was misaligned; rdata = 0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Always ready; no backpressure. One request per port per cycle.
- Word index = addr[log2(DEPTH*BYTES)-1 : log2(BYTES)]. Upper address bits are ignored, so addresses alias modulo DEPTH*BYTES.
- Byte offset = addr[log2(BYTES)-1:0], big-endian lanes: offset 0 maps to bits [WIDTH-1:WIDTH-8].
- Alignment: half requires offset[0]=0; word requires offset=0; size 11 is always misaligned.
- Instruction port: the instruction address's low offset bits are ignored (word fetch).
- Store: byte-lane write enables are derived from size/offset. The write commits at the posedge of the request cycle.
  - Misaligned stores are dropped and produce no response.
  - Stores never raise d_rvalid.
- Load: the array is sampled at the request edge, then lanes are extracted and extended.
  - d_rvalid pulses exactly READ_LATENCY cycles after the request cycle.
  - A misaligned load yields d_rvalid=1, d_misaligned=1, d_rdata=0.
- Read-after-write: a load or fetch in cycle t+1 after a store in cycle t returns the new data.
- Same-cycle collision (instruction read and data store to the same word): the read returns the old word.
- Outputs hold their last value between valids. d_misaligned is 0 whenever d_rvalid is 0.
- Reset:
  - i_rvalid, d_rvalid and d_misaligned go to 0; i_rdata and d_rdata go to 0.
  - All pipeline valid bits clear immediately (in-flight reads are discarded).
  - Array writes are gated off while rst_n=0.
  - Array contents are NOT reset.
- READ_LATENCY=2 adds one register stage after lane extraction. Forwarding behaviour is identical.

Decomposition:
- Package mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - function byte_enables(size, offset)
  - function misaligned(size, offset)
- Sub-module mem_load_align: combinational lane extract plus sign/zero extend, from (word, size, offset, unsigned) to WIDTH result.
- The top level holds the array, write-enable logic and latency pipeline.

Test Plan:
1. Hold rst_n=0 for 3 cycles with requests driven on both ports -> i_rvalid=d_rvalid=d_misaligned=0, rdata=0, and no array write occurs.
2. SW 0xDEADBEEF @0x100 at t; LW @0x100 and fetch @0x102 at t+1 -> both rvalids at t+1+READ_LATENCY with 0xDEADBEEF.
3. From the state in scenario 2, run a series of loads:
   - LB @0x101 -> 0xFFFFFFAD
   - LBU @0x101 -> 0x000000AD
   - LH @0x102 -> 0xFFFFBEEF
   - LHU @0x102 -> 0x0000BEEF
4. SB 0x12 @0x103, then LW @0x100 -> 0xDEADBE12. SH 0x7788 @0x100, then LW -> 0x7788BE12.
5. LW @0x102 -> d_rvalid=1, d_misaligned=1, d_rdata=0. SH 0xFFFF @0x101 -> no response, and a later LW @0x100 still returns 0x7788BE12.
6. Same-cycle fetch @0x100 with SW 0x0 @0x100 -> i_rdata=0x7788BE12. A LW at address 0x100+DEPTH*4 then returns 0x0 (aliasing). Asserting rst_n mid-flight with READ_LATENCY=2 -> no d_rvalid is emitted.
